dem_mode_seq: RTL and testbench
===============================

Name: dem_mode_seq

Overview:
- Mode sequencer for the 18-element ISI/mismatch-shaping DEM core. Sits between the control/register interface and the core's ISI_SEL/MIS_SEL/rstn/clk_en/V inputs.
- Accepts mode-change requests over a valid/ready handshake. Waits for a quiet point in the input code (or a timeout), then mutes the input and holds the core loop filters in reset while the new mode is applied.
- Reports lock once the loops have had a fixed number of samples to settle.

Parameters:
- FLUSH_CYC, 4, clk cycles the core is held in reset (core_rstn low) per mode change.
- SETTLE_CYC, 64, clk_en strobes after flush release before locked asserts.
- QUIET_CYC, 2, consecutive clk_en strobes with V_in==0 required before a flush.
- TIMEOUT_CYC, 1024, clk_en strobes waited for quiet before the flush is forced.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- clk_en  in  1  sample strobe
- V_in  in  6  signed input code from the modulator
- req_valid  in  1  mode request valid
- req_mode  in  2  requested {MIS_SEL,ISI_SEL}
- req_ready  out  1  request accept
- V_out  out  6  signed code to the DEM core
- core_rstn  out  1  active-low reset to the DEM core
- core_clk_en  out  1  clock enable to the DEM core
- ISI_SEL  out  1  ISI bypass to the core
- MIS_SEL  out  1  MIS bypass to the core
- mode_cur  out  2  applied {MIS_SEL,ISI_SEL}
- busy  out  1  mode change in progress
- locked  out  1  core settled in mode_cur
- forced  out  1  sticky flag: last change entered FLUSH via timeout

Behaviour:
- One clock (clk); reset (rst) is synchronous and active-high.
- All outputs registered except core_clk_en, which equals clk_en combinationally.
- Reset values:
  - state=FLUSH, mode_cur=2'b11, ISI_SEL=MIS_SEL=1
  - core_rstn=0, V_out=0, req_ready=0, busy=1, locked=0, forced=0
  - all counters 0
- States:
  - RUN: steady operation.
  - WAIT_Q: waiting for quiet input or timeout.
  - FLUSH: core held in reset, input muted.
  - SETTLE: loops settling after release.
- RUN:
  - req_ready=1, busy=0, locked=1, V_out=V_in registered (1-cycle latency), core_rstn=1.
  - On req_valid&&req_ready: latch req_mode into pend and clear forced.
  - If pend==mode_cur: stay in RUN; no other output changes.
  - Otherwise go to WAIT_Q; req_ready=0, locked=0, busy=1 from the next cycle.
- WAIT_Q:
  - V_out continues to track V_in.
  - On each clk_en: if V_in==0, increment qcnt; otherwise qcnt=0. Also increment tcnt.
  - Go to FLUSH when qcnt reaches QUIET_CYC.
  - Otherwise go to FLUSH with forced=1 when tcnt reaches TIMEOUT_CYC.
  - If both conditions occur on the same strobe, quiet wins and forced stays 0.
- FLUSH entry:
  - In the same cycle: core_rstn=0, V_out=0, ISI_SEL/MIS_SEL/mode_cur = pend.
  - The mode change is therefore never visible while core_rstn=1.
- FLUSH: count FLUSH_CYC clk cycles (independent of clk_en), then go to SETTLE with core_rstn=1.
- SETTLE:
  - V_out tracks V_in.
  - Count SETTLE_CYC clk_en strobes, then go to RUN (locked=1, req_ready=1).
- Requests while not in RUN are not accepted (req_ready=0). The requester holds req_valid and req_mode stable.
- Mode codes 2'b10 and 2'b11 are distinct codes; a change between them still sequences a full flush.
- Counters:
  - Each counter is sized by $clog2 of its parameter+1.
  - Each saturates at its terminal value and clears on state exit.
- rst asserted in any state: the next edge restores the reset values. The pending request is discarded and the requester must re-issue it.
- clk_en low for long periods: WAIT_Q and SETTLE stall, and there is no timeout in clk cycles. FLUSH still completes.

Test Plan:
- rst high 3 cycles, clk_en=1 continuously -> after release, core_rstn=0 for exactly 4 cycles with ISI_SEL=MIS_SEL=1; locked and req_ready rise 64 cycles after core_rstn rises.
- In RUN mode 11, req_mode=00, V_in=5 for 10 strobes then 0 -> FLUSH entered on the 2nd zero strobe; ISI_SEL=MIS_SEL=0 in the same cycle core_rstn falls; V_out=0 for 4 cycles; locked after 64 more strobes; forced=0.
- Zero/nonzero/zero/zero V_in pattern in WAIT_Q -> qcnt restarts; flush begins only after the final two consecutive zeros.
- V_in held at 3, req_mode=01 -> FLUSH after exactly 1024 strobes; forced=1; the next accepted request clears forced.
- Request req_mode equal to mode_cur -> accepted in one cycle; no core_rstn pulse; locked stays 1, busy stays 0.
- clk_en one-in-four during SETTLE, then rst pulsed at SETTLE strobe 30 -> settle progresses only on strobes; the rst pulse returns all outputs to reset values on the next edge and restarts the FLUSH sequence.

Source files
------------

// File: rtl/dem_mode_seq.sv
// Mode sequencer for the 18-element ISI/mismatch-shaping DEM core.
// Accepts a mode request, waits for a quiet point in the input code (or a
// timeout), then mutes the input and holds the core loop filters in reset
// while the new {MIS_SEL,ISI_SEL} is applied. Reports lock once the loops
// have seen a fixed number of samples after release.
module dem_mode_seq #(
    parameter int FLUSH_CYC   = 4,
    parameter int SETTLE_CYC  = 64,
    parameter int QUIET_CYC   = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic [5:0] V_in,
    input  logic       req_valid,
    input  logic [1:0] req_mode,
    output logic       req_ready,
    output logic [5:0] V_out,
    output logic       core_rstn,
    output logic       core_clk_en,
    output logic       ISI_SEL,
    output logic       MIS_SEL,
    output logic [1:0] mode_cur,
    output logic       busy,
    output logic       locked,
    output logic       forced
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_WAIT_Q = 2'd1,
        S_FLUSH  = 2'd2,
        S_SETTLE = 2'd3
    } state_t;

    // Counter widths hold 0..terminal; *_LAST is the value on which the
    // terminal event fires (the counter would reach its parameter).
    localparam int FW = $clog2(FLUSH_CYC + 1);
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int QW = $clog2(QUIET_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [FW-1:0] F_TERM = FW'(FLUSH_CYC);
    localparam logic [FW-1:0] F_LAST = FW'(FLUSH_CYC - 1);
    localparam logic [SW-1:0] S_TERM = SW'(SETTLE_CYC);
    localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [QW-1:0] Q_TERM = QW'(QUIET_CYC);
    localparam logic [QW-1:0] Q_LAST = QW'(QUIET_CYC - 1);
    localparam logic [TW-1:0] T_TERM = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_accept;
    logic          w_quiet_hit;
    logic          w_timeout_hit;
    logic          w_state_chg;

    logic [FW-1:0] r_fcnt;
    logic [SW-1:0] r_scnt;
    logic [QW-1:0] r_qcnt;
    logic [TW-1:0] r_tcnt;

    logic [1:0]    r_pend;
    logic [1:0]    r_mode_cur;
    logic          r_isi_sel;
    logic          r_mis_sel;
    logic          r_core_rstn;
    logic [5:0]    r_v_out;
    logic          r_req_ready;
    logic          r_busy;
    logic          r_locked;
    logic          r_forced;

    // State register; reset lands in FLUSH so the core starts from a clean loop state.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FLUSH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: request accept, quiet/timeout detection, flush and settle terminals.
    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        w_quiet_hit   = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            S_RUN: begin
                w_accept = req_valid && r_req_ready;
                if (w_accept && (req_mode != r_mode_cur)) begin
                    w_state_nxt = S_WAIT_Q;
                end
            end
            S_WAIT_Q: begin
                if (clk_en) begin
                    w_quiet_hit   = (V_in == 6'd0) && (r_qcnt == Q_LAST);
                    w_timeout_hit = (r_tcnt == T_LAST);
                    if (w_quiet_hit || w_timeout_hit) begin
                        w_state_nxt = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (r_fcnt == F_LAST) begin
                    w_state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (clk_en && (r_scnt == S_LAST)) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_FLUSH;
            end
        endcase
        w_state_chg = (w_state_nxt != r_state);
    end

    // Phase counters: saturate at their terminal value, clear on any state exit.
    always_ff @(posedge clk) begin
        if (rst || w_state_chg) begin
            r_fcnt <= '0;
            r_scnt <= '0;
            r_qcnt <= '0;
            r_tcnt <= '0;
        end else begin
            case (r_state)
                S_WAIT_Q: begin
                    if (clk_en) begin
                        if (V_in != 6'd0) begin
                            r_qcnt <= '0;
                        end else if (r_qcnt != Q_TERM) begin
                            r_qcnt <= r_qcnt + 1'b1;
                        end
                        if (r_tcnt != T_TERM) begin
                            r_tcnt <= r_tcnt + 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    if (r_fcnt != F_TERM) begin
                        r_fcnt <= r_fcnt + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (clk_en && (r_scnt != S_TERM)) begin
                        r_scnt <= r_scnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered outputs, decoded from the next state so they change on the same
    // edge as the state; the mode is applied on the edge that enters FLUSH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend      <= 2'b11;
            r_mode_cur  <= 2'b11;
            r_isi_sel   <= 1'b1;
            r_mis_sel   <= 1'b1;
            r_core_rstn <= 1'b0;
            r_v_out     <= 6'd0;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_locked    <= 1'b0;
            r_forced    <= 1'b0;
        end else begin
            r_core_rstn <= (w_state_nxt != S_FLUSH);
            r_v_out     <= (w_state_nxt == S_FLUSH) ? 6'd0 : V_in;
            r_req_ready <= (w_state_nxt == S_RUN);
            r_busy      <= (w_state_nxt != S_RUN);
            r_locked    <= (w_state_nxt == S_RUN);
            if (w_accept) begin
                r_pend   <= req_mode;
                r_forced <= 1'b0;
            end
            if ((r_state == S_WAIT_Q) && (w_state_nxt == S_FLUSH)) begin
                r_mode_cur <= r_pend;
                r_isi_sel  <= r_pend[0];
                r_mis_sel  <= r_pend[1];
                // Quiet wins when both events land on the same strobe.
                r_forced   <= !w_quiet_hit;
            end
        end
    end

    assign core_clk_en = clk_en;
    assign req_ready   = r_req_ready;
    assign V_out       = r_v_out;
    assign core_rstn   = r_core_rstn;
    assign ISI_SEL     = r_isi_sel;
    assign MIS_SEL     = r_mis_sel;
    assign mode_cur    = r_mode_cur;
    assign busy        = r_busy;
    assign locked      = r_locked;
    assign forced      = r_forced;

endmodule

// File: tb/tb_dem_mode_seq.sv
// Directed bench for dem_mode_seq: vector tables for code tracking and the
// quiet-restart pattern, plus hand-written sequences for reset, flush length,
// settle length, timeout, same-mode requests and reset during SETTLE.
module tb_dem_mode_seq;

    logic       clk;
    logic       rst;
    logic       clk_en;
    logic [5:0] V_in;
    logic       req_valid;
    logic [1:0] req_mode;
    logic       req_ready;
    logic [5:0] V_out;
    logic       core_rstn;
    logic       core_clk_en;
    logic       ISI_SEL;
    logic       MIS_SEL;
    logic [1:0] mode_cur;
    logic       busy;
    logic       locked;
    logic       forced;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       en;
        logic [5:0] v_in;
        logic [5:0] exp_vout;
        logic       exp_rstn;
        logic [1:0] exp_mode;
    } vec_t;

    vec_t run_tbl[5];
    vec_t quiet_tbl[5];

    dem_mode_seq dut (
        .clk(clk),
        .rst(rst),
        .clk_en(clk_en),
        .V_in(V_in),
        .req_valid(req_valid),
        .req_mode(req_mode),
        .req_ready(req_ready),
        .V_out(V_out),
        .core_rstn(core_rstn),
        .core_clk_en(core_clk_en),
        .ISI_SEL(ISI_SEL),
        .MIS_SEL(MIS_SEL),
        .mode_cur(mode_cur),
        .busy(busy),
        .locked(locked),
        .forced(forced)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " core_rstn"}, core_rstn, 0);
        check({tag, " V_out"}, V_out, 0);
        check({tag, " req_ready"}, req_ready, 0);
        check({tag, " busy"}, busy, 1);
        check({tag, " locked"}, locked, 0);
        check({tag, " forced"}, forced, 0);
        check({tag, " mode_cur"}, mode_cur, 3);
        check({tag, " ISI_SEL"}, ISI_SEL, 1);
        check({tag, " MIS_SEL"}, MIS_SEL, 1);
    endtask

    // Called on the first cycle core_rstn is low: counts low cycles and verifies muting.
    task automatic expect_flush(input string tag);
        int n;
        int bad_v;
        n = 0;
        bad_v = 0;
        while (core_rstn === 1'b0 && n < 20) begin
            if (V_out !== 6'd0) bad_v++;
            n++;
            step();
        end
        check({tag, " flush_len"}, n, 4);
        check({tag, " flush_vout_muted"}, bad_v, 0);
    endtask

    // Called on the first cycle after core_rstn rises, with clk_en held high.
    task automatic expect_lock(input string tag);
        int m;
        m = 0;
        while (locked !== 1'b1 && m < 200) begin
            step();
            m++;
        end
        check({tag, " settle_len"}, m, 64);
        check({tag, " ready_at_lock"}, req_ready, 1);
        check({tag, " busy_at_lock"}, busy, 0);
    endtask

    task automatic send_req(input logic [1:0] mode);
        req_valid = 1'b1;
        req_mode  = mode;
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        int n;
        int bad;
        int strobes;

        run_tbl[0] = '{1'b1, 6'd5,  6'd5,  1'b1, 2'd3};
        run_tbl[1] = '{1'b0, 6'h3F, 6'h3F, 1'b1, 2'd3};
        run_tbl[2] = '{1'b1, 6'd31, 6'd31, 1'b1, 2'd3};
        run_tbl[3] = '{1'b1, 6'h20, 6'h20, 1'b1, 2'd3};
        run_tbl[4] = '{1'b0, 6'd0,  6'd0,  1'b1, 2'd3};

        // Zero / nonzero / zero / (no strobe) / zero: flush only on the last entry.
        quiet_tbl[0] = '{1'b1, 6'd0, 6'd0, 1'b1, 2'd0};
        quiet_tbl[1] = '{1'b1, 6'd4, 6'd4, 1'b1, 2'd0};
        quiet_tbl[2] = '{1'b1, 6'd0, 6'd0, 1'b1, 2'd0};
        quiet_tbl[3] = '{1'b0, 6'd5, 6'd5, 1'b1, 2'd0};
        quiet_tbl[4] = '{1'b1, 6'd0, 6'd0, 1'b0, 2'd2};

        rst       = 1'b1;
        clk_en    = 1'b1;
        V_in      = 6'd0;
        req_valid = 1'b0;
        req_mode  = 2'd0;

        // Reset for three cycles, then the power-up flush and settle.
        step();
        check_reset_vals("reset");
        step();
        step();
        rst = 1'b0;
        expect_flush("init");
        check("init mode_after_flush", mode_cur, 3);
        expect_lock("init");

        // Code tracking in RUN with one cycle of latency; core_clk_en is combinational.
        for (int i = 0; i < 5; i++) begin
            clk_en = run_tbl[i].en;
            V_in   = run_tbl[i].v_in;
            #1;
            check($sformatf("run[%0d] core_clk_en", i), core_clk_en, run_tbl[i].en);
            step();
            check($sformatf("run[%0d] V_out", i), V_out, run_tbl[i].exp_vout);
            check($sformatf("run[%0d] core_rstn", i), core_rstn, run_tbl[i].exp_rstn);
            check($sformatf("run[%0d] mode_cur", i), mode_cur, run_tbl[i].exp_mode);
        end
        clk_en = 1'b1;

        // Mode 11 -> 00 with nonzero input, then quiet.
        V_in = 6'd5;
        send_req(2'b00);
        check("m00 ready_drop", req_ready, 0);
        check("m00 busy", busy, 1);
        check("m00 locked_drop", locked, 0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (core_rstn !== 1'b1 || mode_cur !== 2'd3 || V_out !== 6'd5) bad++;
        end
        check("m00 wait_nonzero", bad, 0);
        V_in = 6'd0;
        step();
        check("m00 first_zero_rstn", core_rstn, 1);
        step();
        check("m00 second_zero_rstn", core_rstn, 0);
        check("m00 ISI_SEL", ISI_SEL, 0);
        check("m00 MIS_SEL", MIS_SEL, 0);
        check("m00 mode_cur", mode_cur, 0);
        V_in = 6'd7;
        expect_flush("m00");
        check("m00 vout_after_flush", V_out, 7);
        expect_lock("m00");
        check("m00 forced", forced, 0);

        // Quiet counter restart, driven from the table; mode 00 -> 10.
        V_in = 6'd9;
        send_req(2'b10);
        for (int i = 0; i < 5; i++) begin
            clk_en = quiet_tbl[i].en;
            V_in   = quiet_tbl[i].v_in;
            step();
            check($sformatf("quiet[%0d] core_rstn", i), core_rstn, quiet_tbl[i].exp_rstn);
            check($sformatf("quiet[%0d] mode_cur", i), mode_cur, quiet_tbl[i].exp_mode);
            check($sformatf("quiet[%0d] V_out", i), V_out, quiet_tbl[i].exp_vout);
        end
        clk_en = 1'b1;
        expect_flush("m10");
        expect_lock("m10");

        // 10 -> 11 are distinct codes and still get a full flush.
        V_in = 6'd0;
        send_req(2'b11);
        step();
        check("m11 first_zero_rstn", core_rstn, 1);
        step();
        check("m11 flush_rstn", core_rstn, 0);
        check("m11 mode_cur", mode_cur, 3);
        expect_flush("m11");
        expect_lock("m11");

        // Timeout: input never quiet, mode 11 -> 01.
        V_in = 6'd3;
        send_req(2'b01);
        n = 0;
        while (core_rstn === 1'b1 && n < 1100) begin
            step();
            n++;
        end
        check("tmo strobes_to_flush", n, 1024);
        check("tmo forced", forced, 1);
        check("tmo mode_cur", mode_cur, 1);
        check("tmo ISI_SEL", ISI_SEL, 1);
        check("tmo MIS_SEL", MIS_SEL, 0);
        expect_flush("tmo");
        expect_lock("tmo");
        check("tmo forced_sticky", forced, 1);

        // Same-mode request: accepted at once, clears forced, no flush.
        check("same ready_before", req_ready, 1);
        send_req(2'b01);
        check("same forced_cleared", forced, 0);
        check("same busy", busy, 0);
        check("same locked", locked, 1);
        check("same ready", req_ready, 1);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (core_rstn !== 1'b1 || busy !== 1'b0 || locked !== 1'b1) bad++;
        end
        check("same no_pulse", bad, 0);

        // Quiet and timeout on the same strobe: quiet wins, forced stays 0. Mode 01 -> 00.
        V_in = 6'd3;
        send_req(2'b00);
        for (int i = 0; i < 1022; i++) step();
        check("both rstn_before", core_rstn, 1);
        V_in = 6'd0;
        step();
        check("both rstn_1023", core_rstn, 1);
        step();
        check("both rstn_1024", core_rstn, 0);
        check("both forced", forced, 0);
        check("both mode_cur", mode_cur, 0);
        expect_flush("both");

        // SETTLE with one-in-four strobes, then reset on strobe 30.
        strobes = 0;
        bad = 0;
        for (int i = 0; strobes < 29 && i < 400; i++) begin
            clk_en = (i % 4 == 0);
            #1;
            if (core_clk_en !== clk_en) bad++;
            step();
            if (clk_en) strobes++;
            if (locked !== 1'b0 || core_rstn !== 1'b1) bad++;
        end
        check("slow strobes_seen", strobes, 29);
        check("slow no_early_lock", bad, 0);
        check("slow busy", busy, 1);
        clk_en = 1'b1;
        rst    = 1'b1;
        step();
        check_reset_vals("midrst");
        rst = 1'b0;
        expect_flush("midrst");
        expect_lock("midrst");
        check("midrst mode_cur", mode_cur, 3);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (busy !== 1'b0 || core_rstn !== 1'b1) bad++;
        end
        check("midrst pend_discarded", bad, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
